// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-format constants, receiver state type and divisor clamp
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] floor_v);
        return (div < floor_v) ? floor_v : div;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte strobe and line status bundle of the UART receiver
interface uart_rx_if;
    import uart_pkg::*;

    logic                      rx_latch;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      frame_err;
    logic                      rx_break;
    logic                      rx_busy;

    modport master (output rx_latch, output rx_data, output frame_err, output rx_break, output rx_busy);
    modport slave  (input  rx_latch, input  rx_data, input  frame_err, input  rx_break, input  rx_busy);

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with selectable reset value
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with framing-error and line-break detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int MIN_DIV = UART_MIN_DIV
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] baud_div,
    input  logic        rx_in,
    uart_rx_if.master   rx_if
);

    localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic s;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_val (1'b1),
        .d       (rx_in),
        .q       (s)
    );

    uart_rx_state_t state_d, state_q;
    logic [15:0]    cnt_d, cnt_q;
    logic [15:0]    div_d, div_q;
    logic [2:0]     bit_idx_d, bit_idx_q;
    logic [7:0]     shreg_d, shreg_q;
    logic [7:0]     rx_data_d, rx_data_q;
    logic           rx_latch_d, rx_latch_q;
    logic           frame_err_d, frame_err_q;
    logic [15:0]    div_eff;
    logic           cnt_zero;

    assign div_eff  = clamp_div(baud_div, MIN_DIV_W);
    assign cnt_zero = (cnt_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_latch_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Divisor is frozen here so a mid-frame change only affects the next frame.
                if (!s) begin
                    div_d     = div_eff;
                    cnt_d     = (div_eff >> 1) - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = div_q - 16'd1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d   = {s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    cnt_d     = div_q - 16'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (s) begin
                    rx_data_d  = shreg_q;
                    rx_latch_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            div_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_latch_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_latch_q  <= rx_latch_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_if.rx_latch  = rx_latch_q;
    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.rx_break  = (state_q == BREAK);
    assign rx_if.rx_busy   = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] baud_div = 16'd10;
    logic        rx_in = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(.MIN_DIV(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .baud_div (baud_div),
        .rx_in    (rx_in),
        .rx_if    (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         latch_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         glitch_cnt = 0;
    int         last_latch_cyc = 0;
    int         prev_latch_cyc = 0;
    int         last_ferr_cyc = 0;
    logic [7:0] last_latch_data = 8'h00;
    logic [7:0] prev_latch_data = 8'h00;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_data <= u_if.rx_data;
        end else begin
            if (u_if.rx_latch) begin
                latch_cnt       <= latch_cnt + 1;
                prev_latch_cyc  <= last_latch_cyc;
                last_latch_cyc  <= cyc;
                prev_latch_data <= last_latch_data;
                last_latch_data <= u_if.rx_data;
            end
            if (u_if.frame_err) begin
                ferr_cnt      <= ferr_cnt + 1;
                last_ferr_cyc <= cyc;
            end
            if (u_if.rx_latch && u_if.frame_err) both_cnt <= both_cnt + 1;
            if ((u_if.rx_data != prev_data) && !u_if.rx_latch) glitch_cnt <= glitch_cnt + 1;
            prev_data <= u_if.rx_data;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Caller must be at #1 past a rising edge; returns there, 10 bit times later.
    task automatic send_frame(input logic [7:0] d, input int b, input logic stop_v,
                              input int chg_bit, input logic [15:0] chg_div, output int t0);
        t0 = cyc;
        rx_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (b) @(posedge clk);
            #1;
            rx_in = d[i];
            if (i == chg_bit) baud_div = chg_div;
        end
        repeat (b) @(posedge clk);
        #1;
        rx_in = stop_v;
        repeat (b) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] div;
        int          sb;
        logic [7:0]  data;
        logic        stop_v;
        int          exp_latch;
        int          exp_ferr;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0, t1, l0, f0;

        vecs[0] = '{16'd10, 10, 8'hA5, 1'b1, 1, 0, 8'hA5, 98};
        vecs[1] = '{16'd4,  4,  8'h3C, 1'b1, 1, 0, 8'h3C, 41};
        vecs[2] = '{16'd7,  7,  8'h5E, 1'b1, 1, 0, 8'h5E, 69};
        vecs[3] = '{16'd2,  4,  8'h81, 1'b1, 1, 0, 8'h81, 41};
        vecs[4] = '{16'd10, 10, 8'hC3, 1'b0, 0, 1, 8'h81, 98};

        repeat (3) @(posedge clk);
        #1;
        check("rst_latch", int'(u_if.rx_latch), 0);
        check("rst_ferr",  int'(u_if.frame_err), 0);
        check("rst_break", int'(u_if.rx_break), 0);
        check("rst_busy",  int'(u_if.rx_busy), 0);
        check("rst_data",  int'(u_if.rx_data), 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            baud_div = vecs[v].div;
            l0 = latch_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].sb, vecs[v].stop_v, -1, 16'd0, t0);
            rx_in = 1'b1;
            repeat (2 * vecs[v].sb + 10) @(posedge clk);
            #1;
            check($sformatf("v%0d_latch_cnt", v), latch_cnt - l0, vecs[v].exp_latch);
            check($sformatf("v%0d_ferr_cnt", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("v%0d_data", v), int'(u_if.rx_data), int'(vecs[v].exp_data));
            if (vecs[v].exp_latch != 0)
                check($sformatf("v%0d_latency", v), last_latch_cyc - t0, vecs[v].exp_lat);
            else
                check($sformatf("v%0d_ferr_latency", v), last_ferr_cyc - t0, vecs[v].exp_lat);
            check($sformatf("v%0d_break_clear", v), int'(u_if.rx_break), 0);
        end

        // False start: 3-cycle low glitch
        baud_div = 16'd10;
        l0 = latch_cnt;
        f0 = ferr_cnt;
        t0 = cyc;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("glitch_busy_hi", int'(u_if.rx_busy), 1);
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy_lo_c8", int'(u_if.rx_busy), 0);
        check("glitch_elapsed", cyc - t0, 8);
        repeat (100) @(posedge clk);
        #1;
        check("glitch_latch", latch_cnt - l0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);

        // Framing error followed by a long break
        l0 = latch_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 10, 1'b0, -1, 16'd0, t0);
        repeat (400) @(posedge clk);
        #1;
        check("brk_ferr_cnt", ferr_cnt - f0, 1);
        check("brk_latch_cnt", latch_cnt - l0, 0);
        check("brk_ferr_latency", last_ferr_cyc - t0, 98);
        check("brk_data_kept", int'(u_if.rx_data), 8'h81);
        check("brk_level", int'(u_if.rx_break), 1);
        check("brk_not_busy", int'(u_if.rx_busy), 0);
        rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("brk_released", int'(u_if.rx_break), 0);
        send_frame(8'h5A, 10, 1'b1, -1, 16'd0, t0);
        repeat (30) @(posedge clk);
        #1;
        check("brk_next_data", int'(u_if.rx_data), 8'h5A);
        check("brk_next_latency", last_latch_cyc - t0, 98);

        // Back-to-back frames at the minimum divisor
        baud_div = 16'd4;
        l0 = latch_cnt;
        send_frame(8'h00, 4, 1'b1, -1, 16'd0, t0);
        send_frame(8'hFF, 4, 1'b1, -1, 16'd0, t1);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_latch_cnt", latch_cnt - l0, 2);
        check("b2b_spacing", last_latch_cyc - prev_latch_cyc, 40);
        check("b2b_first_latency", prev_latch_cyc - t0, 41);
        check("b2b_first_data", int'(prev_latch_data), 8'h00);
        check("b2b_second_data", int'(last_latch_data), 8'hFF);

        // Reset during bit 4 of 0x81
        baud_div = 16'd10;
        l0 = latch_cnt;
        f0 = ferr_cnt;
        rx_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(posedge clk);
            #1;
            rx_in = (i == 0) ? 1'b1 : 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check("rstmid_busy", int'(u_if.rx_busy), 0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        check("rstmid_latch", latch_cnt - l0, 0);
        check("rstmid_ferr", ferr_cnt - f0, 0);
        check("rstmid_data", int'(u_if.rx_data), 8'h00);
        send_frame(8'h81, 10, 1'b1, -1, 16'd0, t0);
        repeat (30) @(posedge clk);
        #1;
        check("rstmid_next_data", int'(u_if.rx_data), 8'h81);

        // Divisor change mid-frame takes effect on the next frame only
        baud_div = 16'd10;
        send_frame(8'h96, 10, 1'b1, 2, 16'd20, t0);
        repeat (40) @(posedge clk);
        #1;
        check("divchg_data", int'(u_if.rx_data), 8'h96);
        check("divchg_latency", last_latch_cyc - t0, 98);
        send_frame(8'h69, 20, 1'b1, -1, 16'd0, t1);
        repeat (50) @(posedge clk);
        #1;
        check("div20_data", int'(u_if.rx_data), 8'h69);
        check("div20_latency", last_latch_cyc - t1, 193);

        check("never_both_strobes", both_cnt, 0);
        check("data_only_on_latch", glitch_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
